// File: rtl/vdec_hs_pkg.sv
// Shared definitions for the HS decoder CRC checker: mode encodings,
// payload lengths, CRC polynomial and checker FSM states.
package vdec_hs_pkg;

  // hs_mode encodings; any mode with bit 1 set is an AGCH check
  localparam logic [1:0] HS_P1 = 2'b00;
  localparam logic [1:0] HS_P2 = 2'b01;
  localparam logic [1:0] HS_AG = 2'b10;

  // Payload lengths covered by the CRC
  localparam int PAY_P2 = 21;
  localparam int PAY_AG = 6;

  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_PAY,
    ST_RD_CRC,
    ST_DRAIN,
    ST_DONE
  } crc_state_t;

endpackage

// File: rtl/vdec_crc16_ser.sv
// One-bit-per-cycle CRC-16 LFSR (MSB-first, initial value 0, no final
// inversion). Shared with the SER stage.
module vdec_crc16_ser
  import vdec_hs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        d,
  output logic [15:0] crc
);

  logic fb;

  assign fb = crc[15] ^ d;

  // Shift one data bit into the LFSR when enabled; clear wins over enable
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples its inputs before any of them update.
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/vdec_hs_crc.sv
// Bit-serial CRC-16 checker for HS-SCCH part2 and AGCH blocks. Reads the
// payload and received CRC from the traceback bit buffer, recomputes the
// CRC, applies the UE mask and reports a registered match.
module vdec_hs_crc #(
  parameter int PAY_P2 = vdec_hs_pkg::PAY_P2,
  parameter int PAY_AG = vdec_hs_pkg::PAY_AG,
  parameter int AW     = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          crc_start,
  input  logic [1:0]    hs_mode,
  input  logic          agch_crc_sel,
  input  logic [15:0]   ue_id,
  input  logic [15:0]   ernti_pri,
  input  logic [15:0]   ernti_sec,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_data,
  output logic          crc_done,
  output logic          crc_match,
  output logic          crc_busy
);

  import vdec_hs_pkg::*;

  crc_state_t    state;
  logic [AW-1:0] last_pay;   // address of the final payload bit (N-1)
  logic [AW-1:0] last_crc;   // address of the final CRC bit (N+15)
  logic [15:0]   mask;
  logic [15:0]   rx;
  logic [15:0]   rx_next;
  logic [15:0]   lfsr;
  logic          data_vld;   // rd_data carries a requested bit this cycle
  logic          data_crc;   // that bit belongs to the received CRC field
  logic          start_acc;
  logic          lfsr_en;

  assign start_acc = crc_start && (state == ST_IDLE);
  assign lfsr_en   = data_vld && !data_crc;
  // The last CRC bit arrives in the same cycle the result is registered,
  // so the comparator looks at rx with that bit already shifted in.
  assign rx_next   = {rx[14:0], rd_data};

  vdec_crc16_ser u_crc (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (lfsr_en),
    .d   (rd_data),
    .crc (lfsr)
  );

  // Control FSM, address counter, mask latch, rx shift register and result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      crc_done  <= 1'b0;
      crc_match <= 1'b0;
      crc_busy  <= 1'b0;
      data_vld  <= 1'b0;
      data_crc  <= 1'b0;
      rx        <= '0;
      mask      <= '0;
      last_pay  <= '0;
      last_crc  <= '0;
    end else begin
      data_vld <= rd_en;
      data_crc <= (state == ST_RD_CRC);
      crc_done <= 1'b0;
      if (data_vld && data_crc) begin
        rx <= rx_next;
      end

      case (state)
        ST_IDLE: begin
          if (crc_start) begin
            crc_match <= 1'b0;
            crc_busy  <= 1'b1;
            rd_addr   <= '0;
            rx        <= '0;
            if (hs_mode == HS_P1) begin
              // No payload to check: report a miss right away
              crc_done <= 1'b1;
              state    <= ST_DONE;
            end else if (hs_mode == HS_P2) begin
              mask     <= ue_id;
              last_pay <= AW'(PAY_P2 - 1);
              last_crc <= AW'(PAY_P2 + 15);
              rd_en    <= 1'b1;
              state    <= ST_RD_PAY;
            end else begin
              mask     <= agch_crc_sel ? ernti_sec : ernti_pri;
              last_pay <= AW'(PAY_AG - 1);
              last_crc <= AW'(PAY_AG + 15);
              rd_en    <= 1'b1;
              state    <= ST_RD_PAY;
            end
          end
        end

        ST_RD_PAY: begin
          if (rd_addr == last_pay) begin
            state <= ST_RD_CRC;
          end
          rd_addr <= rd_addr + AW'(1);
        end

        ST_RD_CRC: begin
          if (rd_addr == last_crc) begin
            rd_en <= 1'b0;
            state <= ST_DRAIN;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end

        ST_DRAIN: begin
          crc_done  <= 1'b1;
          crc_match <= ((lfsr ^ mask) == rx_next);
          state     <= ST_DONE;
        end

        ST_DONE: begin
          crc_busy <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
